// File: rtl/save_ram_pkg.sv
// Shared types and constants for the save-RAM channel-2 controller.
// Contents:
//   state_t        - sequencer states for the save (SDRAM->buffer) and load
//                    (buffer->SDRAM) byte-copy loops
//   SAVE_BASE_ADDR - SDRAM byte address of save-RAM offset 0
//   SAVE_MAX_LEN   - largest transfer in bytes (equals the save-buffer depth)
//   clamp_len()    - limits a requested length to the buffer depth
package save_ram_pkg;

  typedef enum logic [3:0] {
    IDLE,
    SV_RD,
    SV_WAIT,
    SV_WR,
    LD_ADDR,
    LD_LATCH,
    LD_WR,
    LD_WAIT,
    FINISH
  } state_t;

  localparam logic [24:0] SAVE_BASE_ADDR = 25'h3C0000;
  localparam int unsigned SAVE_MAX_LEN   = 32768;

  function automatic logic [15:0] clamp_len(input logic [15:0] req_len,
                                            input logic [15:0] max_len);
    return (req_len > max_len) ? max_len : req_len;
  endfunction

endpackage

// File: rtl/save_ram_ch2_mux.sv
// Channel-2 ownership mux. While the savestate engine sleeps the core it
// owns SDRAM ch2 outright and its strobes pass straight through; otherwise
// the save-RAM sequencer drives the channel. Read data is shared.
// Ports:
//   sleep_savestate       - 1: savestate engine owns ch2
//   ss_addr/rd/wr/wdata   - savestate request;   ss_rdata - its read data
//   fsm_addr/rd/wr/din    - sequencer request
//   ch2_addr/rd/wr/din    - to SDRAM ch2;        ch2_dout - from SDRAM ch2
module save_ram_ch2_mux (
  input  logic        sleep_savestate,
  input  logic [24:0] ss_addr,
  input  logic        ss_rd,
  input  logic        ss_wr,
  input  logic [7:0]  ss_wdata,
  output logic [7:0]  ss_rdata,
  input  logic [24:0] fsm_addr,
  input  logic        fsm_rd,
  input  logic        fsm_wr,
  input  logic [7:0]  fsm_din,
  output logic [24:0] ch2_addr,
  output logic        ch2_rd,
  output logic        ch2_wr,
  output logic [7:0]  ch2_din,
  input  logic [7:0]  ch2_dout
);

  always_comb begin
    ch2_addr = fsm_addr;
    ch2_rd   = fsm_rd;
    ch2_wr   = fsm_wr;
    ch2_din  = fsm_din;
    if (sleep_savestate) begin
      ch2_addr = ss_addr;
      ch2_rd   = ss_rd;
      ch2_wr   = ss_wr;
      ch2_din  = ss_wdata;
    end
  end

  assign ss_rdata = ch2_dout;

endmodule

// File: rtl/save_ram_ctrl.sv
// Save-RAM sequencer for SDRAM channel 2 (clk_ppu_21_47 domain).
// Copies battery-backed PRG NVRAM byte by byte between the SDRAM save region
// and the host save buffer: load (buffer->SDRAM) at boot, save
// (SDRAM->buffer) on host request. The savestate engine preempts the
// sequencer whenever sleep_savestate is high.
// Ports:
//   clk, reset_n              - clock, async active-low reset
//   save_req/load_req/xfer_len- transfer request, sampled in IDLE only
//   save_written              - core wrote NVRAM (sets dirty)
//   sleep_savestate, ss_*     - savestate engine access to ch2
//   ch2_*                     - SDRAM channel 2
//   buf_addr/wr/din/dout      - save buffer (1-cycle read latency)
//   busy, done, core_hold     - transfer status; core_hold during loads
//   dirty                     - NVRAM modified since last completed save
// Build option: define SAVE_RAM_CHECKSUM_EN to add output checksum[15:0],
// the 16-bit sum of every byte moved by the most recent transfer.
module save_ram_ctrl
  import save_ram_pkg::*;
#(
  parameter logic [24:0] BASE_ADDR = SAVE_BASE_ADDR,
  parameter int unsigned MAX_LEN   = SAVE_MAX_LEN
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        save_req,
  input  logic        load_req,
  input  logic [15:0] xfer_len,
  input  logic        save_written,
  input  logic        sleep_savestate,
  input  logic [24:0] ss_addr,
  input  logic        ss_rd,
  input  logic        ss_wr,
  input  logic [7:0]  ss_wdata,
  output logic [7:0]  ss_rdata,
  output logic [24:0] ch2_addr,
  output logic        ch2_rd,
  output logic        ch2_wr,
  output logic [7:0]  ch2_din,
  input  logic [7:0]  ch2_dout,
  input  logic        ch2_busy,
  output logic [14:0] buf_addr,
  output logic        buf_wr,
  output logic [7:0]  buf_din,
  input  logic [7:0]  buf_dout,
  output logic        busy,
  output logic        done,
  output logic        core_hold,
  output logic        dirty
`ifdef SAVE_RAM_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);

  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

  state_t      state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] len_q, len_d;
  logic        is_load_q, is_load_d;
  logic        seen_q, seen_d;     // save_written observed during this save
  logic        skip_q, skip_d;     // first wait cycle after a strobe
  logic        dirty_q, dirty_d;
  logic [7:0]  data_q, data_d;     // byte in flight; needs no reset
  logic [15:0] idx_inc;
  logic [15:0] req_len;
  logic        fsm_rd, fsm_wr;
  logic [7:0]  fsm_din;
  logic [24:0] fsm_addr;

  assign idx_inc = idx_q + 16'd1;
  assign req_len = clamp_len(xfer_len, MAX_LEN_W);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    is_load_d = is_load_q;
    seen_d    = seen_q | save_written;
    skip_d    = 1'b0;
    dirty_d   = dirty_q | save_written;
    data_d    = data_q;
    fsm_rd    = 1'b0;
    fsm_wr    = 1'b0;
    buf_wr    = 1'b0;
    done      = 1'b0;
    // Every transfer state holds while the savestate engine owns ch2, so
    // the copy resumes at the same idx once sleep_savestate falls.
    unique case (state_q)
      IDLE: begin
        seen_d = save_written;
        if (load_req || save_req) begin
          is_load_d = load_req;
          len_d     = req_len;
          idx_d     = '0;
          if (req_len == 16'd0) state_d = FINISH;
          else if (load_req)    state_d = LD_ADDR;
          else                  state_d = SV_RD;
        end
      end
      SV_RD: begin
        if (!sleep_savestate && !ch2_busy) begin
          fsm_rd  = 1'b1;
          skip_d  = 1'b1;
          state_d = SV_WAIT;
        end
      end
      SV_WAIT: begin
        // Read data is only valid on the cycle busy is seen low.
        if (!skip_q && !sleep_savestate && !ch2_busy) begin
          data_d  = ch2_dout;
          state_d = SV_WR;
        end
      end
      SV_WR: begin
        if (!sleep_savestate) begin
          buf_wr  = 1'b1;
          idx_d   = idx_inc;
          state_d = (idx_inc == len_q) ? FINISH : SV_RD;
        end
      end
      LD_ADDR: begin
        if (!sleep_savestate) state_d = LD_LATCH;
      end
      LD_LATCH: begin
        if (!sleep_savestate) begin
          data_d  = buf_dout;
          state_d = LD_WR;
        end
      end
      LD_WR: begin
        if (!sleep_savestate && !ch2_busy) begin
          fsm_wr  = 1'b1;
          skip_d  = 1'b1;
          state_d = LD_WAIT;
        end
      end
      LD_WAIT: begin
        if (!skip_q && !sleep_savestate && !ch2_busy) begin
          idx_d   = idx_inc;
          state_d = (idx_inc == len_q) ? FINISH : LD_ADDR;
        end
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
        dirty_d = is_load_q ? 1'b0 : (seen_q | save_written);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      is_load_q <= 1'b0;
      seen_q    <= 1'b0;
      skip_q    <= 1'b0;
      dirty_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      is_load_q <= is_load_d;
      seen_q    <= seen_d;
      skip_q    <= skip_d;
      dirty_q   <= dirty_d;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  // Address is held for the whole access so the SDRAM may latch it at any
  // point between strobe and completion.
  always_comb begin
    fsm_addr = '0;
    if (state_q == SV_RD || state_q == SV_WAIT ||
        state_q == LD_WR || state_q == LD_WAIT)
      fsm_addr = BASE_ADDR + {9'd0, idx_q};
  end

  assign fsm_din   = fsm_wr ? data_q : 8'h00;
  assign buf_din   = buf_wr ? data_q : 8'h00;
  assign buf_addr  = idx_q[14:0];
  assign busy      = (state_q != IDLE);
  assign core_hold = is_load_q && (state_q != IDLE);
  assign dirty     = dirty_q;

  save_ram_ch2_mux u_mux (
    .sleep_savestate (sleep_savestate),
    .ss_addr         (ss_addr),
    .ss_rd           (ss_rd),
    .ss_wr           (ss_wr),
    .ss_wdata        (ss_wdata),
    .ss_rdata        (ss_rdata),
    .fsm_addr        (fsm_addr),
    .fsm_rd          (fsm_rd),
    .fsm_wr          (fsm_wr),
    .fsm_din         (fsm_din),
    .ch2_addr        (ch2_addr),
    .ch2_rd          (ch2_rd),
    .ch2_wr          (ch2_wr),
    .ch2_din         (ch2_din),
    .ch2_dout        (ch2_dout)
  );

`ifdef SAVE_RAM_CHECKSUM_EN
  logic [15:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (state_q == IDLE && (load_req || save_req))
      checksum_d = '0;
    else if ((state_q == SV_WR && !sleep_savestate) || fsm_wr)
      checksum_d = checksum_q + {8'h00, data_q};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) checksum_q <= '0;
    else          checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_save_ram_ctrl.sv
// Directed bench for save_ram_ctrl: a table of whole transfers plus
// hand-written sequences for preemption, request priority, zero length,
// mid-transfer reset and dirty tracking. Includes a small SDRAM ch2 model
// (3-cycle busy after each strobe) and a save-buffer model (1-cycle read).
module tb_save_ram_ctrl;

  localparam logic [24:0] BASE = 25'h3C0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        save_req, load_req;
  logic [15:0] xfer_len;
  logic        save_written;
  logic        sleep_savestate;
  logic [24:0] ss_addr;
  logic        ss_rd, ss_wr;
  logic [7:0]  ss_wdata, ss_rdata;
  logic [24:0] ch2_addr;
  logic        ch2_rd, ch2_wr;
  logic [7:0]  ch2_din, ch2_dout;
  logic        ch2_busy;
  logic [14:0] buf_addr;
  logic        buf_wr;
  logic [7:0]  buf_din, buf_dout;
  logic        busy, done, core_hold, dirty;
`ifdef SAVE_RAM_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  save_ram_ctrl dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .save_req        (save_req),
    .load_req        (load_req),
    .xfer_len        (xfer_len),
    .save_written    (save_written),
    .sleep_savestate (sleep_savestate),
    .ss_addr         (ss_addr),
    .ss_rd           (ss_rd),
    .ss_wr           (ss_wr),
    .ss_wdata        (ss_wdata),
    .ss_rdata        (ss_rdata),
    .ch2_addr        (ch2_addr),
    .ch2_rd          (ch2_rd),
    .ch2_wr          (ch2_wr),
    .ch2_din         (ch2_din),
    .ch2_dout        (ch2_dout),
    .ch2_busy        (ch2_busy),
    .buf_addr        (buf_addr),
    .buf_wr          (buf_wr),
    .buf_din         (buf_din),
    .buf_dout        (buf_dout),
    .busy            (busy),
    .done            (done),
    .core_hold       (core_hold),
    .dirty           (dirty)
`ifdef SAVE_RAM_CHECKSUM_EN
    ,
    .checksum        (checksum)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- models ----------------
  logic [7:0]  sdram [logic [24:0]];
  logic [7:0]  sbuf  [0:32767];
  logic [2:0]  busy_cnt;
  logic [32:0] wr_log [$];   // {addr, data} of every ch2 write
  logic [24:0] rd_log [$];   // addr of every ch2 read
  logic [22:0] bw_log [$];   // {addr, data} of every buffer write

  assign ch2_busy = (busy_cnt != 3'd0);

  initial begin
    busy_cnt = 3'd0;
    ch2_dout = 8'h00;
    buf_dout = 8'h00;
    forever begin
      @(posedge clk);
      if (ch2_rd || ch2_wr) begin
        busy_cnt <= 3'd3;
        if (ch2_wr) begin
          sdram[ch2_addr] = ch2_din;
          wr_log.push_back({ch2_addr, ch2_din});
        end else begin
          rd_log.push_back(ch2_addr);
          ch2_dout <= sdram.exists(ch2_addr) ? sdram[ch2_addr] : 8'h00;
        end
      end else if (busy_cnt != 3'd0) begin
        busy_cnt <= busy_cnt - 3'd1;
      end
      buf_dout <= sbuf[buf_addr];
      if (buf_wr) begin
        sbuf[buf_addr] = buf_din;
        bw_log.push_back({buf_addr, buf_din});
      end
    end
  end

  // ---------------- monitor ----------------
  int done_cnt  = 0;
  int hold_viol = 0;
  bit cur_is_load = 1'b0;

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (busy && (core_hold != cur_is_load)) hold_viol <= hold_viol + 1;
  end

  // ---------------- checking ----------------
  int nvec = 0;
  int nmis = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_xfer(input bit ld, input logic [15:0] len);
    cur_is_load = ld;
    xfer_len    = len;
    load_req    = ld;
    save_req    = !ld;
    tick();
    load_req    = 1'b0;
    save_req    = 1'b0;
  endtask

  task automatic wait_done(input int dc0);
    int n = 0;
    while (done_cnt == dc0 && n < 3000) begin
      tick();
      n++;
    end
    repeat (3) tick();
  endtask

  task automatic pulse_written();
    save_written = 1'b1;
    tick();
    save_written = 1'b0;
    tick();
  endtask

  typedef struct {
    bit          load;
    logic [15:0] len;
    logic [63:0] pat;       // byte i at bits [8i+7:8i]
    bit          exp_dirty;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int ws, bs, rs, dc, hv, n;
    logic [7:0] b;

    vecs[0] = '{load: 1'b1, len: 16'd4, pat: 64'h0000_0000_4433_2211, exp_dirty: 1'b0};
    vecs[1] = '{load: 1'b0, len: 16'd3, pat: 64'h0000_0000_00CC_BBAA, exp_dirty: 1'b0};
    vecs[2] = '{load: 1'b0, len: 16'd8, pat: 64'h8877_6655_4433_2211, exp_dirty: 1'b0};
    vecs[3] = '{load: 1'b1, len: 16'd1, pat: 64'h0000_0000_0000_005A, exp_dirty: 1'b0};
    vecs[4] = '{load: 1'b0, len: 16'd0, pat: 64'h0000_0000_0000_0000, exp_dirty: 1'b0};

    reset_n = 1'b0; save_req = 1'b0; load_req = 1'b0; xfer_len = 16'd0;
    save_written = 1'b0; sleep_savestate = 1'b0;
    ss_addr = 25'd0; ss_rd = 1'b0; ss_wr = 1'b0; ss_wdata = 8'h00;
    for (int i = 0; i < 32768; i++) sbuf[i] = 8'h00;
    sdram[25'h100000] = 8'h5E;

    repeat (3) tick();
    check("reset outputs", 64'({ch2_addr, ch2_rd, ch2_wr, ch2_din, buf_addr, buf_wr,
                               buf_din, busy, done, core_hold, dirty}), 64'd0);
    reset_n = 1'b1;
    tick();
    check("idle after reset busy", 64'(busy), 64'd0);

    // ---------- table of whole transfers ----------
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < int'(vecs[v].len); i++) begin
        b = vecs[v].pat[8*i +: 8];
        if (vecs[v].load) sbuf[i] = b;
        else              sdram[BASE + 25'(i)] = b;
      end
      pulse_written();
      check($sformatf("v%0d dirty before", v), 64'(dirty), 64'd1);
      ws = wr_log.size(); bs = bw_log.size(); rs = rd_log.size();
      dc = done_cnt; hv = hold_viol;
      start_xfer(vecs[v].load, vecs[v].len);
      wait_done(dc);
      check($sformatf("v%0d done pulses", v), 64'(done_cnt - dc), 64'd1);
      check($sformatf("v%0d dirty after", v), 64'(dirty), 64'(vecs[v].exp_dirty));
      check($sformatf("v%0d core_hold", v), 64'(hold_viol - hv), 64'd0);
      if (vecs[v].load) begin
        check($sformatf("v%0d ch2 writes", v), 64'(wr_log.size() - ws), 64'(vecs[v].len));
        for (int i = 0; i < int'(vecs[v].len) && ws + i < wr_log.size(); i++)
          check($sformatf("v%0d wr%0d", v, i), 64'(wr_log[ws+i]),
                64'({BASE + 25'(i), vecs[v].pat[8*i +: 8]}));
      end else begin
        check($sformatf("v%0d ch2 reads", v), 64'(rd_log.size() - rs), 64'(vecs[v].len));
        check($sformatf("v%0d buf writes", v), 64'(bw_log.size() - bs), 64'(vecs[v].len));
        for (int i = 0; i < int'(vecs[v].len) && bs + i < bw_log.size(); i++)
          check($sformatf("v%0d bw%0d", v, i), 64'(bw_log[bs+i]),
                64'({15'(i), vecs[v].pat[8*i +: 8]}));
      end
    end

    // ---------- savestate preemption during an 8-byte save ----------
    for (int i = 0; i < 8; i++) sdram[BASE + 25'(i)] = 8'(8'h10 + i);
    bs = bw_log.size(); rs = rd_log.size(); dc = done_cnt;
    start_xfer(1'b0, 16'd8);
    n = 0;
    while (bw_log.size() < bs + 2 && n < 500) begin tick(); n++; end
    check("pre bytes before sleep", 64'(bw_log.size() - bs), 64'd2);
    sleep_savestate = 1'b1;
    ss_addr = 25'h100000;
    ss_rd   = 1'b1;
    tick();
    ss_rd   = 1'b0;
    tick();
    n = 0;
    while (ch2_busy && n < 20) begin tick(); n++; end
    check("pre ss_rdata", 64'(ss_rdata), 64'h5E);
    repeat (45) tick();
    check("pre no buf write asleep", 64'(bw_log.size() - bs), 64'd2);
    sleep_savestate = 1'b0;
    wait_done(dc);
    check("pre done", 64'(done_cnt - dc), 64'd1);
    check("pre read count", 64'(rd_log.size() - rs), 64'd9);
    if (rd_log.size() >= rs + 4) begin
      check("pre ss read addr", 64'(rd_log[rs+2]), 64'h100000);
      check("pre resume addr", 64'(rd_log[rs+3]), 64'(BASE + 25'd2));
    end
    check("pre buf writes", 64'(bw_log.size() - bs), 64'd8);
    for (int i = 0; i < 8 && bs + i < bw_log.size(); i++)
      check($sformatf("pre bw%0d", i), 64'(bw_log[bs+i]), 64'({15'(i), 8'(8'h10 + i)}));

    // ---------- simultaneous requests: load wins ----------
    sbuf[0] = 8'h77; sbuf[1] = 8'h88;
    ws = wr_log.size(); bs = bw_log.size(); rs = rd_log.size();
    dc = done_cnt; hv = hold_viol;
    cur_is_load = 1'b1;
    xfer_len = 16'd2; load_req = 1'b1; save_req = 1'b1;
    tick();
    load_req = 1'b0; save_req = 1'b0;
    check("both core_hold", 64'(core_hold), 64'd1);
    wait_done(dc);
    check("both done", 64'(done_cnt - dc), 64'd1);
    check("both ch2 writes", 64'(wr_log.size() - ws), 64'd2);
    check("both no reads", 64'(rd_log.size() - rs), 64'd0);
    check("both no buf writes", 64'(bw_log.size() - bs), 64'd0);
    check("both hold", 64'(hold_viol - hv), 64'd0);
    if (wr_log.size() >= ws + 2) begin
      check("both wr0", 64'(wr_log[ws]),   64'({BASE, 8'h77}));
      check("both wr1", 64'(wr_log[ws+1]), 64'({BASE + 25'd1, 8'h88}));
    end

    // ---------- zero length: done one cycle later, no strobe ----------
    ws = wr_log.size(); rs = rd_log.size(); dc = done_cnt;
    cur_is_load = 1'b0;
    xfer_len = 16'd0; save_req = 1'b1;
    tick();
    save_req = 1'b0;
    check("zero done next cycle", 64'(done), 64'd1);
    tick();
    check("zero done low", 64'({done, busy}), 64'd0);
    repeat (3) tick();
    check("zero strobes", 64'((wr_log.size() - ws) + (rd_log.size() - rs)), 64'd0);
    check("zero single done", 64'(done_cnt - dc), 64'd1);

    // ---------- async reset mid-load ----------
    for (int i = 0; i < 8; i++) sbuf[i] = 8'(8'hA0 + i);
    pulse_written();
    ws = wr_log.size(); dc = done_cnt;
    start_xfer(1'b1, 16'd8);
    n = 0;
    while (wr_log.size() < ws + 5 && n < 500) begin tick(); n++; end
    check("rst writes before", 64'(wr_log.size() - ws), 64'd5);
    reset_n = 1'b0;
    #1;
    check("rst outputs", 64'({ch2_addr, ch2_rd, ch2_wr, ch2_din, buf_addr, buf_wr,
                             buf_din, busy, done, core_hold, dirty}), 64'd0);
    repeat (3) tick();
    reset_n = 1'b1;
    cur_is_load = 1'b0;
    repeat (5) tick();
    check("rst idle", 64'({busy, dirty}), 64'd0);
    check("rst no done", 64'(done_cnt - dc), 64'd0);
    check("rst no more writes", 64'(wr_log.size() - ws), 64'd5);

    // ---------- save_written during a save keeps dirty ----------
    sdram[BASE] = 8'hFF; sdram[BASE + 25'd1] = 8'hFF; sdram[BASE + 25'd2] = 8'h02;
    bs = bw_log.size(); dc = done_cnt;
    start_xfer(1'b0, 16'd3);
    tick();
    save_written = 1'b1;
    tick();
    save_written = 1'b0;
    wait_done(dc);
    check("sw done", 64'(done_cnt - dc), 64'd1);
    check("sw dirty kept", 64'(dirty), 64'd1);
    check("sw buf writes", 64'(bw_log.size() - bs), 64'd3);
`ifdef SAVE_RAM_CHECKSUM_EN
    check("checksum", 64'(checksum), 64'h0200);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/save_ram_ctrl.md
Name: save_ram_ctrl

Overview:
- Sequencer and arbiter for SDRAM channel 2, the backup-RAM/savestate port.
- Copies battery-backed PRG NVRAM between the SDRAM save region and the host save buffer (sd_buff), byte by byte: load on boot, save on host request.
- Shares ch2 with the savestate engine; savestate always wins.
- Sits between the NES core, the sdram block and the bridge save buffer, in the clk_ppu_21_47 domain.

Parameters:
- BASE_ADDR, 25'h3C0000, SDRAM byte address of save-RAM offset 0.
- MAX_LEN, 32768, maximum transfer length in bytes; equals the buffer depth.

Ports:
- clk  in  1  system clock (clk_ppu_21_47).
- reset_n  in  1  asynchronous active-low reset.
- save_req  in  1  start SDRAM->buffer copy; sampled in IDLE only.
- load_req  in  1  start buffer->SDRAM copy; sampled in IDLE only.
- xfer_len  in  16  byte count; sampled together with the request.
- save_written  in  1  core wrote NVRAM; sets dirty.
- sleep_savestate  in  1  savestate engine owns ch2.
- ss_addr  in  25  savestate address.
- ss_rd  in  1  savestate read strobe.
- ss_wr  in  1  savestate write strobe.
- ss_wdata  in  8  savestate write data.
- ss_rdata  out  8  savestate read data (= ch2_dout).
- ch2_addr  out  25  SDRAM ch2 address.
- ch2_rd  out  1  SDRAM ch2 read strobe.
- ch2_wr  out  1  SDRAM ch2 write strobe.
- ch2_din  out  8  SDRAM ch2 write data.
- ch2_dout  in  8  SDRAM ch2 read data.
- ch2_busy  in  1  SDRAM ch2 busy.
- buf_addr  out  15  save-buffer address.
- buf_wr  out  1  save-buffer write enable.
- buf_din  out  8  save-buffer write data.
- buf_dout  in  8  save-buffer read data; 1-cycle latency.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at transfer end.
- core_hold  out  1  hold the NES core in reset during a load.
- dirty  out  1  NVRAM modified since the last completed save.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; counters 0; dirty 0. Reset mid-transfer aborts immediately; no done pulse.
- Ch2 mux: when sleep_savestate=1, ch2_* are driven combinationally from ss_*; the FSM issues nothing. Otherwise the FSM drives ch2_*.
- Ch2 handshake:
  - Strobe is a 1-cycle pulse, issued only when ch2_busy=0.
  - After a strobe, skip one cycle, then wait for ch2_busy=0.
  - Read data is valid on the cycle ch2_busy is seen low.
- IDLE:
  - load_req has priority over save_req when both are high.
  - Length latch: len = min(xfer_len, MAX_LEN).
  - len=0: pulse done next cycle, stay IDLE.
  - Requests are ignored while busy, except by sampling in IDLE.
- SAVE path:
  - SV_RD: ch2_rd, ch2_addr = BASE_ADDR + idx.
  - SV_WAIT: wait for ch2_busy=0.
  - SV_WR: buf_wr=1, buf_addr=idx, buf_din=ch2_dout; idx++.
  - Then SV_RD, or FINISH when idx==len.
- LOAD path:
  - LD_ADDR: buf_addr=idx.
  - LD_LATCH: capture buf_dout.
  - LD_WR: ch2_wr, ch2_din = captured byte.
  - LD_WAIT: wait for ch2_busy=0; idx++.
  - Then LD_ADDR, or FINISH when idx==len.
- Savestate preemption: FSM advances only when sleep_savestate=0. If it rises mid-transfer:
  - An outstanding ch2 access completes; its wait ignores ch2_busy until sleep_savestate falls.
  - The next strobe is withheld until sleep_savestate falls.
  - Resume at the same idx; no byte lost or duplicated.
- FINISH: done=1 for one cycle, return to IDLE.
- busy=1 in every state except IDLE. core_hold=1 throughout the LD_* states and FINISH of a load.
- Dirty:
  - save_written sets dirty.
  - FINISH of a save clears dirty, unless save_written was seen at any point during that save (dirty stays 1).
  - Load FINISH clears dirty.
- Widths: idx is 16 bits; buf_addr = idx[14:0]; ch2_addr = BASE_ADDR + idx, modulo 2^25.

Optional Feature:
- Macro: SAVE_RAM_CHECKSUM_EN.
- Defined: adds output checksum[15:0], the modulo-2^16 sum of every byte transferred.
  - Cleared when a transfer starts.
  - Stable from the done pulse until the next start.
- Undefined: no checksum logic; port is absent.

Decomposition:
- Package save_ram_pkg:
  - FSM state enum: IDLE, SV_RD, SV_WAIT, SV_WR, LD_ADDR, LD_LATCH, LD_WR, LD_WAIT, FINISH.
  - Constants: SAVE_BASE_ADDR, SAVE_MAX_LEN.
- One sub-module, save_ram_ch2_mux: combinational savestate/FSM ch2 mux. The FSM stays in save_ram_ctrl.

Test Plan:
- Load, len=4, buffer {11,22,33,44}: ch2 writes 0x3C0000..0x3C0003 with those bytes; core_hold=1 throughout; single done pulse.
- Save, len=3, SDRAM model 0x3C0000..02 = {AA,BB,CC}: buf_wr at addr 0,1,2 with {AA,BB,CC}; dirty 1->0 at done.
- sleep_savestate raised after byte 1 of an 8-byte save for 50 cycles with ss_rd at 0x100000: savestate access completes; FSM resumes at idx 2; all 8 bytes correct.
- save_req and load_req in the same cycle: load executes; save ignored. Then xfer_len=0: done one cycle later with no ch2 strobe.
- Async reset_n low mid-load at idx 5: all outputs 0 within reset; no done. After release, dirty=0 and FSM in IDLE.
- save_written pulsed during a save: dirty remains 1 after done. With SAVE_RAM_CHECKSUM_EN, checksum of {FF,FF,02} = 0x0200.
